// File: rtl/traffic_sensor_conditioner.sv
// Input stage for the traffic light controller: synchronises and debounces the
// raw street A/B car sensors on a slow tick and latches each arrival as a request.
module traffic_sensor_conditioner #(
  parameter int TICK_DIV       = 50000,
  parameter int DEBOUNCE_TICKS = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sa_raw,
  input  logic       sb_raw,
  input  logic       ack_a,
  input  logic       ack_b,
  output logic       lvl_a,
  output logic       lvl_b,
  output logic       req_a,
  output logic       req_b,
  output logic       tick,
  output logic [1:0] state_a,
  output logic [1:0] state_b
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    SERVED  = 2'd2
  } req_state_t;

  logic [PW-1:0] pcnt;
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    lvl;
  logic [CW-1:0] dcnt [2];
  logic [1:0]    ack;
  logic [1:0]    req;
  req_state_t    state_q [2];
  req_state_t    state_d [2];

  // Index 0 is street A, index 1 is street B throughout.
  assign ack = {ack_b, ack_a};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
    end else if (pcnt == TICK_LAST) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

  assign tick = (pcnt == TICK_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {sb_raw, sa_raw};
      sync2 <= sync1;
    end
  end

  // Any tick on which the input agrees with the current level restarts the count,
  // so only an uninterrupted run of DEBOUNCE_TICKS ticks flips the level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl <= '0;
      for (int i = 0; i < 2; i++) dcnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == lvl[i]) begin
          dcnt[i] <= '0;
        end else if (tick) begin
          if (dcnt[i] == DEB_LAST) begin
            lvl[i]  <= ~lvl[i];
            dcnt[i] <= '0;
          end else begin
            dcnt[i] <= dcnt[i] + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) state_q[i] <= IDLE;
    end else begin
      for (int i = 0; i < 2; i++) state_q[i] <= state_d[i];
    end
  end

  // Request/ack handshake: req stays high from the level rising until the first
  // cycle ack is seen high; afterwards the channel ignores ack and re-arms only
  // once the debounced level has returned to 0.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        IDLE:    if (lvl[i])  state_d[i] = PENDING;
        PENDING: if (ack[i])  state_d[i] = SERVED;
        SERVED:  if (!lvl[i]) state_d[i] = IDLE;
        default: state_d[i] = IDLE;
      endcase
    end
  end

  always_comb begin
    req = '0;
    for (int i = 0; i < 2; i++) req[i] = (state_q[i] == PENDING);
  end

  assign lvl_a   = lvl[0];
  assign lvl_b   = lvl[1];
  assign req_a   = req[0];
  assign req_b   = req[1];
  assign state_a = state_q[0];
  assign state_b = state_q[1];

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Directed bench for traffic_sensor_conditioner (TICK_DIV=4, DEBOUNCE_TICKS=3):
// expected output-change events are queued by the stimulus and matched by a monitor.
module tb_traffic_sensor_conditioner;

  logic       clk;
  logic       rst_n;
  logic       sa_raw;
  logic       sb_raw;
  logic       ack_a;
  logic       ack_b;
  logic       lvl_a;
  logic       lvl_b;
  logic       req_a;
  logic       req_b;
  logic       tick;
  logic [1:0] state_a;
  logic [1:0] state_b;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  // Entry layout: [19:4] cycle of the change, [3:0] {lvl_a, lvl_b, req_a, req_b}.
  logic [19:0] exp_q[$];
  logic [19:0] e;
  logic [3:0]  prev = 4'b0000;
  logic [3:0]  cur;

  traffic_sensor_conditioner #(
    .TICK_DIV      (4),
    .DEBOUNCE_TICKS(3)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .sa_raw (sa_raw),
    .sb_raw (sb_raw),
    .ack_a  (ack_a),
    .ack_b  (ack_b),
    .lvl_a  (lvl_a),
    .lvl_b  (lvl_b),
    .req_a  (req_a),
    .req_b  (req_b),
    .tick   (tick),
    .state_a(state_a),
    .state_b(state_b)
  );

  // clock / reset-relative cycle count
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic push(input logic [15:0] c, input logic [3:0] v);
    exp_q.push_back({c, v});
  endtask

  task automatic wait_until(input int c);
    int n = 0;
    while (cyc != c && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (cyc != c) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_timeout: cycle %0d, expected to reach %0d", cyc, c);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    cur = {lvl_a, lvl_b, req_a, req_b};
    check("tick", {31'd0, tick}, {31'd0, (rst_n && (cyc % 4 == 3))});
    if (!rst_n) begin
      prev = cur;
    end else if (cur !== prev) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_change: got %b at cycle %0d, expected no change", cur, cyc);
      end else begin
        e = exp_q.pop_front();
        check("event_cycle", cyc, {16'd0, e[19:4]});
        check("event_value", {28'd0, cur}, {28'd0, e[3:0]});
      end
      prev = cur;
    end
  end

  // driver
  initial begin
    rst_n  = 1'b0;
    sa_raw = 1'b0;
    sb_raw = 1'b0;
    ack_a  = 1'b0;
    ack_b  = 1'b0;

    // reset state, then idle with ticks only
    repeat (3) @(negedge clk);
    check("reset_outputs", {27'd0, lvl_a, lvl_b, req_a, req_b, tick}, 32'd0);
    check("reset_states", {28'd0, state_a, state_b}, 32'd0);
    #2 rst_n = 1'b1;
    wait_until(20);

    // clean rise on A
    sa_raw = 1'b1;
    push(32, 4'b1000);
    push(33, 4'b1010);

    // A drops while pending: request kept until ack
    wait_until(36);
    sa_raw = 1'b0;
    push(48, 4'b0010);
    wait_until(52);
    ack_a = 1'b1;
    push(53, 4'b0000);
    wait_until(53);
    ack_a = 1'b0;
    wait_until(56);
    check("a_idle_after_ack", {30'd0, state_a}, 32'd0);

    // re-raise A, serve it while car present, car leaves
    wait_until(60);
    sa_raw = 1'b1;
    push(72, 4'b1000);
    push(73, 4'b1010);
    wait_until(76);
    ack_a = 1'b1;
    push(77, 4'b1000);
    wait_until(77);
    ack_a = 1'b0;
    wait_until(80);
    sa_raw = 1'b0;
    push(92, 4'b0000);

    // ack in IDLE is ignored
    wait_until(96);
    ack_a = 1'b1;
    wait_until(97);
    ack_a = 1'b0;
    wait_until(98);
    check("a_idle_ignores_ack", {30'd0, state_a}, 32'd0);

    // 6-cycle glitch on A: no events expected
    wait_until(100);
    sa_raw = 1'b1;
    wait_until(106);
    sa_raw = 1'b0;
    wait_until(120);

    // simultaneous A and B, ack_b held for 10 cycles
    sa_raw = 1'b1;
    sb_raw = 1'b1;
    push(132, 4'b1100);
    push(133, 4'b1111);
    wait_until(136);
    ack_b = 1'b1;
    push(137, 4'b1110);
    wait_until(146);
    ack_b = 1'b0;
    wait_until(150);
    check("b_served", {30'd0, state_b}, 32'd2);
    check("a_pending", {30'd0, state_a}, 32'd1);

    // B leaves and re-arrives so req_b is set again
    wait_until(160);
    sb_raw = 1'b0;
    push(172, 4'b1010);
    wait_until(176);
    sb_raw = 1'b1;
    push(188, 4'b1110);
    push(189, 4'b1111);

    // A starts debouncing low; reset lands with its counter at 2
    wait_until(190);
    sa_raw = 1'b0;
    wait_until(201);
    #2 rst_n = 1'b0;
    #1 check("async_reset_outputs", {27'd0, lvl_a, lvl_b, req_a, req_b, tick}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    push(12, 4'b0100);
    push(13, 4'b0101);
    wait_until(5);
    sa_raw = 1'b1;
    push(16, 4'b1101);
    push(17, 4'b1111);
    wait_until(24);

    check("events_outstanding", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time exceeded, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
